// File: rtl/timer_pkg.sv
// Register map, control bit positions and byte-lane helper shared by the timer top and its compare channels.
// Pure declarations: no logic, no latency, no flow control.
package timer_pkg;
    localparam logic [3:0] REG_CTRL = 4'd0;
    localparam logic [3:0] REG_PRE  = 4'd1;
    localparam logic [3:0] REG_SNAP = 4'd2;
    localparam logic [3:0] REG_IRQ  = 4'd3;
    localparam int         CMP_BASE = 4;
    localparam int         CHC_BASE = 5;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_SNAP   = 2;
    localparam int CHC_EN      = 0;
    localparam int CHC_ONESHOT = 1;
    localparam int OVF_BIT     = 7;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] sel);
        return word[{sel, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/timer_cmp_ch.sv
// One compare channel: CMP/CHC registers, match detect on the incrementing count, one-shot auto-disable.
// Match is combinational on the tick cycle; readback is zero-latency; no backpressure (bus writes always accepted).
module timer_cmp_ch
    import timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       adr,
    input  logic [7:0]       din,
    input  logic             wr_en,
    input  logic             tick,
    input  logic [CNT_W-1:0] cnt_inc,
    output logic             match,
    output logic [7:0]       rd_dat
);
    localparam logic [3:0] CMP_IDX = 4'(CMP_BASE + 2 * IDX);
    localparam logic [3:0] CHC_IDX = 4'(CHC_BASE + 2 * IDX);

    logic [CNT_W-1:0] cmp;
    logic             ch_en;
    logic             oneshot;
    logic             wr_cmp;
    logic             wr_chc;

    assign wr_cmp = wr_en && (adr[5:2] == CMP_IDX);
    assign wr_chc = wr_en && (adr[5:2] == CHC_IDX) && (adr[1:0] == 2'd0);
    assign match  = tick && ch_en && (cnt_inc == cmp);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp     <= '0;
            ch_en   <= 1'b0;
            oneshot <= 1'b0;
        end else begin
            for (int i = 0; i < CNT_W; i++) begin
                if (wr_cmp && (32'(adr[1:0]) == i / 8))
                    cmp[i] <= din[3'(i % 8)];
            end
            // A software write to CHC overrides the one-shot auto-disable.
            if (wr_chc) begin
                ch_en   <= din[CHC_EN];
                oneshot <= din[CHC_ONESHOT];
            end else if (match && oneshot) begin
                ch_en <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        if (adr[5:2] == CMP_IDX)
            rd_dat = byte_sel(32'(cmp), adr[1:0]);
        else if ((adr[5:2] == CHC_IDX) && (adr[1:0] == 2'd0))
            rd_dat = {6'd0, oneshot, ch_en};
    end
endmodule

// File: rtl/timer_multi_simp_bus.sv
// Timer/compare unit on the byte-wide simple bus: prescaler, free-running counter, snapshot, NCH compare channels, sticky W1C irq.
// Reads are combinational (zero latency), writes take effect on the next edge, irq is one clk behind pending; no backpressure.
module timer_multi_simp_bus
    import timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16,
    parameter int NCH   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] adr,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic [7:0] dout,
    output logic       irq
);
    logic [3:0]       reg_idx;
    logic [1:0]       byte_idx;
    logic             run;
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_max;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] snap;
    logic [7:0]       pending;
    logic [7:0]       irq_mask;
    logic [7:0]       pend_set;
    logic [7:0]       w1c;
    logic             wr_ctrl;
    logic             wr_pre;
    logic             clr;
    logic             snap_stb;
    logic             tick;
    logic             cnt_tick;
    logic             ovf;
    logic [NCH-1:0]   match;
    logic [7:0]       ch_rd [NCH];
    logic [7:0]       ch_rd_or;

    assign reg_idx  = adr[5:2];
    assign byte_idx = adr[1:0];
    assign wr_ctrl  = wr_en && (reg_idx == REG_CTRL) && (byte_idx == 2'd0);
    assign wr_pre   = wr_en && (reg_idx == REG_PRE);
    assign clr      = wr_ctrl && din[CTRL_CLR];
    assign snap_stb = wr_ctrl && din[CTRL_SNAP];
    assign tick     = run && (pre_cnt >= pre_max);
    // A clear swallows a coincident tick, so it can never produce a match or overflow.
    assign cnt_tick = tick && !clr;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign ovf      = cnt_tick && (&cnt);
    assign w1c      = (wr_en && (reg_idx == REG_IRQ) && (byte_idx == 2'd0)) ? din : 8'd0;

    always_comb begin
        pend_set          = '0;
        pend_set[NCH-1:0] = match;
        pend_set[OVF_BIT] = ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run      <= 1'b0;
            pre_cnt  <= '0;
            pre_max  <= '0;
            cnt      <= '0;
            snap     <= '0;
            pending  <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl)
                run <= din[CTRL_RUN];
            if (clr) begin
                cnt     <= '0;
                pre_cnt <= '0;
            end else if (tick) begin
                cnt     <= cnt_inc;
                pre_cnt <= '0;
            end else if (run) begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
            if (snap_stb)
                snap <= cnt;
            for (int i = 0; i < PRE_W; i++) begin
                if (wr_pre && (32'(byte_idx) == i / 8))
                    pre_max[i] <= din[3'(i % 8)];
            end
            if (wr_en && (reg_idx == REG_IRQ) && (byte_idx == 2'd1))
                irq_mask <= din;
            // Set beats clear when both hit the same bit on the same edge.
            pending <= (pending & ~w1c) | pend_set;
            irq     <= |(pending & irq_mask);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        timer_cmp_ch #(
            .CNT_W(CNT_W),
            .IDX  (c)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .adr    (adr),
            .din    (din),
            .wr_en  (wr_en),
            .tick   (cnt_tick),
            .cnt_inc(cnt_inc),
            .match  (match[c]),
            .rd_dat (ch_rd[c])
        );
    end

    always_comb begin
        ch_rd_or = '0;
        for (int c = 0; c < NCH; c++)
            ch_rd_or = ch_rd_or | ch_rd[c];
    end

    always_comb begin
        dout = '0;
        case (reg_idx)
            REG_CTRL: if (byte_idx == 2'd0) dout = {7'd0, run};
            REG_PRE:  dout = byte_sel(32'(pre_max), byte_idx);
            REG_SNAP: dout = byte_sel(32'(snap), byte_idx);
            REG_IRQ: begin
                if (byte_idx == 2'd0)
                    dout = pending;
                else if (byte_idx == 2'd1)
                    dout = irq_mask;
            end
            default:  dout = ch_rd_or;
        endcase
    end
endmodule

// File: tb/tb_timer_multi_simp_bus.sv
// Randomised bench for timer_multi_simp_bus (8-bit counter, 4 channels) with a scoreboard and an integer reference model.
// Stimulus pushes expected read data and irq; a negedge monitor pops and compares.
module tb_timer_multi_simp_bus;
    localparam int CNT_W   = 8;
    localparam int PRE_W   = 16;
    localparam int NCH     = 4;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int PRE_MOD = 1 << PRE_W;
    localparam int A_CTRL  = 0;
    localparam int A_PRE   = 4;
    localparam int A_SNAP  = 8;
    localparam int A_PEND  = 12;
    localparam int A_MASK  = 13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] adr = '0;
    logic [7:0] din = '0;
    logic       wr_en = 1'b0;
    logic [7:0] dout;
    logic       irq;

    timer_multi_simp_bus #(.CNT_W(CNT_W), .PRE_W(PRE_W), .NCH(NCH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .adr  (adr),
        .din  (din),
        .wr_en(wr_en),
        .dout (dout),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        logic [7:0] msk;
        logic       exp_irq;
        string      name;
    } chk_t;

    chk_t sb[$];
    chk_t mc;
    logic mon_vld = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model: architectural state as plain integers.
    int m_run, m_pre_cnt, m_pre_max, m_cnt, m_snap, m_pend, m_mask, m_irq;
    int m_cmp [NCH];
    int m_en  [NCH];
    int m_os  [NCH];

    function automatic int a_cmp(input int c);
        return (4 + 2 * c) * 4;
    endfunction

    function automatic int a_chc(input int c);
        return (5 + 2 * c) * 4;
    endfunction

    function automatic void model_reset();
        m_run = 0; m_pre_cnt = 0; m_pre_max = 0; m_cnt = 0;
        m_snap = 0; m_pend = 0; m_mask = 0; m_irq = 0;
        for (int c = 0; c < NCH; c++) begin
            m_cmp[c] = 0; m_en[c] = 0; m_os[c] = 0;
        end
    endfunction

    function automatic int model_read(input int a);
        int idx, sel, c;
        idx = a / 4;
        sel = a % 4;
        if (idx == 0) return (sel == 0) ? m_run : 0;
        if (idx == 1) return (sel < 2) ? ((m_pre_max >> (8 * sel)) & 255) : 0;
        if (idx == 2) return (sel == 0) ? m_snap : 0;
        if (idx == 3) return (sel == 0) ? m_pend : ((sel == 1) ? m_mask : 0);
        if (idx >= 4 && idx < 4 + 2 * NCH && sel == 0) begin
            c = (idx - 4) / 2;
            return (idx % 2 == 0) ? m_cmp[c] : (m_os[c] * 2 + m_en[c]);
        end
        return 0;
    endfunction

    function automatic bit tick_now();
        return (m_run != 0) && (m_pre_cnt >= m_pre_max);
    endfunction

    function automatic bit ch_match_next(input int c);
        return tick_now() && (m_en[c] != 0) && (((m_cnt + 1) % CNT_MOD) == m_cmp[c]);
    endfunction

    function automatic void model_step(input int a, input int d, input int w);
        int idx, sel, c, set, w1c, nxt_cnt, nxt_pre, nxt_irq;
        int n_en [NCH];
        bit clr;
        idx = a / 4;
        sel = a % 4;
        nxt_irq = ((m_pend & m_mask) != 0) ? 1 : 0;
        clr = (w != 0) && idx == 0 && sel == 0 && ((d & 2) != 0);
        set = 0;
        w1c = 0;
        nxt_cnt = m_cnt;
        nxt_pre = m_pre_cnt;
        for (int k = 0; k < NCH; k++) n_en[k] = m_en[k];
        if (clr) begin
            nxt_cnt = 0;
            nxt_pre = 0;
        end else if (tick_now()) begin
            nxt_cnt = (m_cnt + 1) % CNT_MOD;
            nxt_pre = 0;
            if (nxt_cnt == 0) set = set | 'h80;
            for (int k = 0; k < NCH; k++) begin
                if (m_en[k] != 0 && nxt_cnt == m_cmp[k]) begin
                    set = set | (1 << k);
                    if (m_os[k] != 0) n_en[k] = 0;
                end
            end
        end else if (m_run != 0) begin
            nxt_pre = (m_pre_cnt + 1) % PRE_MOD;
        end
        if (w != 0) begin
            if (idx == 0 && sel == 0) begin
                m_run = d & 1;
                if ((d & 4) != 0) m_snap = m_cnt;
            end else if (idx == 1 && sel < 2) begin
                m_pre_max = (m_pre_max & ~(255 << (8 * sel))) | ((d & 255) << (8 * sel));
            end else if (idx == 3 && sel == 0) begin
                w1c = d & 255;
            end else if (idx == 3 && sel == 1) begin
                m_mask = d & 255;
            end else if (idx >= 4 && idx < 4 + 2 * NCH && sel == 0) begin
                c = (idx - 4) / 2;
                if (idx % 2 == 0) m_cmp[c] = d & 255;
                else begin
                    n_en[c] = d & 1;
                    m_os[c] = (d >> 1) & 1;
                end
            end
        end
        m_pend = ((m_pend & ~w1c) | set) & 255;
        m_cnt = nxt_cnt;
        m_pre_cnt = nxt_pre;
        m_irq = nxt_irq;
        for (int k = 0; k < NCH; k++) m_en[k] = n_en[k];
    endfunction

    // One bus cycle; when chk is set, the expected dout (model value or cexp) and irq are queued.
    task automatic cyc(input int a, input int d, input bit w, input bit chk, input string name,
                       input int cexp = -1, input int msk = 255);
        chk_t e;
        adr = a[5:0];
        din = d[7:0];
        wr_en = w;
        mon_vld = chk;
        if (chk) begin
            e.exp = (cexp < 0) ? 8'(model_read(a)) : 8'(cexp);
            e.msk = 8'(msk);
            e.exp_irq = (m_irq != 0);
            e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        if (rst_n) model_step(a, d, int'(w));
        else model_reset();
        #1;
    endtask

    task automatic idle_read();
        cyc(int'($urandom_range(0, 63)), 0, 1'b0, 1'b1, "rand_rd");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 0, 1'b0, 1'b0, "rst");
        rst_n = 1'b1;
    endtask

    task automatic run_until_cnt(input int tgt, input string name);
        int k;
        k = 0;
        while (m_cnt != tgt && k < 600) begin
            idle_read();
            k++;
        end
        if (m_cnt != tgt) begin
            n_chk++;
            $display("FAIL %s timeout: count reached %0d, wanted %0d", name, m_cnt, tgt);
        end
    endtask

    always @(negedge clk) begin
        if (mon_vld) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL scoreboard_empty: monitor saw a read with nothing expected");
            end else begin
                mc = sb.pop_front();
                n_chk++;
                if ((dout & mc.msk) === (mc.exp & mc.msk)) n_pass++;
                else $display("FAIL %s dout: got %02h want %02h (mask %02h) adr %0d",
                              mc.name, dout, mc.exp, mc.msk, adr);
                n_chk++;
                if (irq === mc.exp_irq) n_pass++;
                else $display("FAIL %s irq: got %b want %b", mc.name, irq, mc.exp_irq);
            end
        end
    end

    int  r, a, d, c;
    bit  found;

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Every address reads zero out of reset.
        for (int i = 0; i < 64; i++) cyc(i, 0, 1'b0, 1'b1, "reset_rd", 0);

        // Prescale by 4: twenty clocks give five ticks.
        cyc(A_PRE, 3, 1'b1, 1'b0, "wr");
        cyc(A_CTRL, 1, 1'b1, 1'b0, "wr");
        for (int i = 0; i < 20; i++) idle_read();
        cyc(A_CTRL, 5, 1'b1, 1'b0, "wr");
        cyc(A_SNAP, 0, 1'b0, 1'b1, "snap_pre3", 5);

        // One-shot channel 0 at 0x10 with prescale 1.
        cyc(A_CTRL, 2, 1'b1, 1'b0, "wr");
        cyc(A_PEND, 255, 1'b1, 1'b0, "wr");
        cyc(A_PRE, 0, 1'b1, 1'b0, "wr");
        cyc(a_cmp(0), 'h10, 1'b1, 1'b0, "wr");
        cyc(a_chc(0), 3, 1'b1, 1'b0, "wr");
        cyc(A_MASK, 1, 1'b1, 1'b1, "mask_wr");
        cyc(A_CTRL, 1, 1'b1, 1'b0, "wr");
        cyc(A_CTRL, 5, 1'b1, 1'b0, "wr");
        cyc(A_CTRL, 5, 1'b1, 1'b0, "wr");
        cyc(A_SNAP, 0, 1'b0, 1'b1, "snap_every_clk", 1);
        run_until_cnt('h10, "oneshot");
        cyc(A_PEND, 0, 1'b0, 1'b1, "oneshot_pend", 1, 1);
        cyc(a_chc(0), 0, 1'b0, 1'b1, "oneshot_chc", 2);
        cyc(A_PEND, 1, 1'b1, 1'b1, "oneshot_w1c");
        run_until_cnt(0, "wrap");
        run_until_cnt('h20, "past_cmp");
        cyc(A_PEND, 0, 1'b0, 1'b1, "no_refire_ovf", 'h80, 'h81);

        // Continuous channel 1: W1C on the very cycle of a match keeps the bit.
        cyc(a_cmp(1), 5, 1'b1, 1'b0, "wr");
        cyc(a_chc(1), 1, 1'b1, 1'b0, "wr");
        cyc(A_MASK, 2, 1'b1, 1'b0, "wr");
        found = 0;
        for (int k = 0; k < 600 && !found; k++) begin
            if (ch_match_next(1)) begin
                cyc(A_PEND, 2, 1'b1, 1'b1, "w1c_vs_set");
                found = 1;
            end else begin
                idle_read();
            end
        end
        if (!found) begin
            n_chk++;
            $display("FAIL w1c_vs_set timeout: no channel 1 match seen");
        end
        cyc(A_PEND, 0, 1'b0, 1'b1, "pend1_kept", 2, 2);
        cyc(A_PEND, 2, 1'b1, 1'b1, "w1c_alone");
        cyc(A_PEND, 0, 1'b0, 1'b1, "pend1_clr", 0, 2);
        cyc(A_PEND, 0, 1'b0, 1'b1, "irq_fall");

        // Clear strobe on a tick cycle with channel 0 armed at 0.
        cyc(a_cmp(0), 0, 1'b1, 1'b0, "wr");
        cyc(a_chc(0), 1, 1'b1, 1'b0, "wr");
        run_until_cnt('h40, "to_41");
        cyc(A_PEND, 255, 1'b1, 1'b0, "wr");
        cyc(A_CTRL, 3, 1'b1, 1'b1, "clr_on_tick");
        cyc(A_CTRL, 5, 1'b1, 1'b0, "wr");
        cyc(A_SNAP, 0, 1'b0, 1'b1, "clr_snap", 0);
        cyc(A_PEND, 0, 1'b0, 1'b1, "clr_no_event", 0, 'h81);

        // Reset while running.
        do_reset();
        for (int i = 0; i < 64; i++) cyc(i, 0, 1'b0, 1'b1, "midrun_rst", 0);

        // Each channel sets only its own bit.
        for (int k = 0; k < NCH; k++) begin
            cyc(a_cmp(k), 'h20 + 'h10 * k, 1'b1, 1'b0, "wr");
            cyc(a_chc(k), 1, 1'b1, 1'b0, "wr");
        end
        cyc(A_MASK, 'h0F, 1'b1, 1'b0, "wr");
        cyc(A_CTRL, 1, 1'b1, 1'b0, "wr");
        for (int k = 0; k < NCH; k++) begin
            run_until_cnt('h20 + 'h10 * k, "ch_seq");
            cyc(A_PEND, 0, 1'b0, 1'b1, "ch_own_bit", (1 << (k + 1)) - 1, 'h0F);
        end
        for (int i = 48; i < 64; i++) cyc(i, 0, 1'b0, 1'b1, "unmapped_rd", 0);

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                idle_read();
            end else begin
                if (r < 65) begin
                    a = A_CTRL;
                    d = (($urandom_range(0, 7) != 0) ? 1 : 0) | (($urandom_range(0, 9) == 0) ? 2 : 0)
                        | (int'($urandom_range(0, 1)) * 4);
                end else if (r < 75) begin
                    a = A_PEND;
                    d = int'($urandom_range(0, 255));
                end else if (r < 80) begin
                    a = A_MASK;
                    d = int'($urandom_range(0, 255));
                end else if (r < 85) begin
                    a = A_PRE + int'($urandom_range(0, 1));
                    d = (a == A_PRE) ? int'($urandom_range(0, 3)) : (($urandom_range(0, 15) == 0) ? 1 : 0);
                end else if (r < 95) begin
                    c = int'($urandom_range(0, NCH - 1));
                    if ($urandom_range(0, 1) == 0) begin
                        a = a_cmp(c);
                        d = int'($urandom_range(0, 255));
                    end else begin
                        a = a_chc(c);
                        d = int'($urandom_range(0, 3));
                    end
                end else begin
                    a = int'($urandom_range(0, 63));
                    d = int'($urandom_range(0, 255));
                end
                cyc(a, d, 1'b1, 1'b1, "rand_wr");
            end
        end

        cyc(0, 0, 1'b0, 1'b0, "end");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
